vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in clocks.
REQ-002 SHALL have parameter H_BACK, default 48, meaning horizontal back porch in clocks.
REQ-003 SHALL have parameter H_VALID, default 640, meaning visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in clocks.
REQ-005 SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-006 SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-007 SHALL have parameter V_VALID, default 480, meaning visible lines per frame.
REQ-008 SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-009 SHALL have port vga_clk, input, 1, meaning pixel clock; all logic on rising edge.
REQ-010 SHALL have port sys_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-011 SHALL have port pix_data, input, 12, meaning RGB444 from the pixel generator, registered by it one clock after pix_x/pix_y.
REQ-012 SHALL have port pix_x, output, 10, meaning requested column, 0..H_VALID-1.
REQ-013 SHALL have port pix_y, output, 10, meaning requested row, 0..V_VALID-1.
REQ-014 SHALL have port pix_req, output, 1, meaning pix_x/pix_y are inside the visible area.
REQ-015 SHALL have port hsync, output, 1, meaning horizontal sync, active low.
REQ-016 SHALL have port vsync, output, 1, meaning vertical sync, active low.
REQ-017 SHALL have port de, output, 1, meaning rgb carries a visible pixel.
REQ-018 SHALL have port rgb, output, 12, meaning RGB444 to the DAC pins.
REQ-019 SHALL have port frame_start, output, 1, meaning one-clock pulse aligned with the first output clock of each frame.

Function
REQ-020 SHALL derive H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT (800), V_TOTAL = V_SYNC+V_BACK+V_VALID+V_FRONT (525), H_ACT = H_SYNC+H_BACK (144), V_ACT = V_SYNC+V_BACK (35).
REQ-021 SHALL run h_cnt 0..H_TOTAL-1, incrementing every clock and wrapping to 0 after H_TOTAL-1.
REQ-022 SHALL increment v_cnt only in the clock where h_cnt wraps, wrapping to 0 when v_cnt = V_TOTAL-1 at that same clock.
REQ-023 SHALL drive pix_req combinationally high iff h_cnt in [H_ACT, H_ACT+H_VALID) and v_cnt in [V_ACT, V_ACT+V_VALID).
REQ-024 SHALL drive pix_x = h_cnt-H_ACT and pix_y = v_cnt-V_ACT while pix_req = 1, and 0 while pix_req = 0.
REQ-025 SHALL form raw sync as hs_raw = (h_cnt >= H_SYNC) and vs_raw = (v_cnt >= V_SYNC), i.e. low during the pulse.
REQ-026 SHALL delay hs_raw, vs_raw, pix_req, and frame-start decode (h_cnt=0, v_cnt=0) through exactly 2 register stages to hsync, vsync, de, and frame_start.
REQ-027 SHALL register rgb <= pix_data when the 1-stage-delayed pix_req is 1, else rgb <= 0; latency from pix_x/pix_y to rgb is exactly 2 clocks.
REQ-028 SHALL never pass pix_data to rgb outside the visible area, whatever its value (including X).
REQ-029 SHALL keep hsync toggling during vertical blanking; the vsync edge SHALL coincide with an hsync falling edge.

Reset
REQ-030 SHALL, while sys_rst_n = 0, hold h_cnt = 0, v_cnt = 0, hsync = 1, vsync = 1, de = 0, rgb = 0, frame_start = 0, and clear all pipeline stages.
REQ-031 SHALL, on reset release, start at h_cnt = 0, v_cnt = 0; frame_start SHALL pulse 2 clocks after the first active edge.
REQ-032 SHALL, on reset asserted mid-frame, drop de and rgb to 0 immediately (asynchronously) with no partial pixel emitted afterwards.

Structure
REQ-033 SHALL take the timing constants (H_SYNC..V_FRONT, H_TOTAL, V_TOTAL) and colour constants from the team's shared parameter file, which the pixel generator also uses.
REQ-034 SHALL be a single module; an optional sub-module vga_delay_line (parameterised width and depth) MAY implement the 2-stage alignment pipeline.

Verification
REQ-035 Reset held 10 clocks, then released -> hsync = vsync = 1, rgb = 0, de = 0 during reset; frame_start high exactly at clock 2 after release.
REQ-036 Run 2 lines -> hsync low for 96 consecutive clocks every 800; de high for 640 consecutive clocks starting 144 clocks after each hsync falling edge (lines 35..514 only).
REQ-037 Generator model returns pix_data = {pix_y[3:0], pix_x[7:0]} registered -> rgb at de clock n of line k equals {k[3:0], n[7:0]}; first pixel 12'h000, last pixel of line 0 is 12'h07F.
REQ-038 Full frame -> vsync low for 2 x 800 clocks, frame period 420000 clocks, pix_req never high for v_cnt < 35 or v_cnt >= 515.
REQ-039 pix_data forced to 12'hFFF/X outside pix_req -> rgb = 0 whenever de = 0.
REQ-040 Reset asserted at line 200, pixel 300 -> rgb = 0, de = 0 asynchronously; after release the next de pulse starts 35 x 800 + 144 + 2 clocks later.

Source files
------------

// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA timing and colour constants, also used by the pixel generator.
// Holds the 640x480@60 default timing, the counter width, the black level
// driven on rgb outside the visible area, and the control bundle that travels
// down the output alignment pipeline.
package vga_timing_ctrl_pkg;

    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_VALID = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_VALID = 480;
    localparam int VGA_V_FRONT = 10;

    localparam int CNT_W = 10;

    localparam logic [11:0] RGB_BLACK = 12'h000;

    // Control bits aligned with rgb; sync fields are active low.
    typedef struct packed {
        logic hs;
        logic vs;
        logic req;
        logic fs;
    } vga_ctl_t;

    // Pipeline contents while idle/reset: syncs deasserted, nothing visible.
    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, req: 1'b0, fs: 1'b0};

    function automatic int vga_total(input int sync_w, input int back_w,
                                     input int valid_w, input int front_w);
        return sync_w + back_w + valid_w + front_w;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-latency register pipeline with a configurable idle value.
// Ports:
//   vga_clk    - clock, rising edge
//   sys_rst_n  - asynchronous active-low reset, loads RST_VAL into every stage
//   din        - WIDTH-bit input
//   dout       - din delayed by DEPTH clocks
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe <= {DEPTH{RST_VAL}};
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator with pixel request and output alignment.
// Ports:
//   vga_clk     - pixel clock, rising edge
//   sys_rst_n   - asynchronous active-low reset
//   pix_data    - RGB444 from the pixel generator, one clock after pix_x/pix_y
//   pix_x/pix_y - requested visible column/row (0 outside the visible area)
//   pix_req     - pix_x/pix_y are inside the visible area
//   hsync/vsync - active-low syncs, aligned with rgb
//   de          - rgb carries a visible pixel
//   rgb         - RGB444 to the DAC, black outside the visible area
//   frame_start - one-clock pulse on the first output clock of each frame
module vga_timing_ctrl
    import vga_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BACK  = VGA_H_BACK,
    parameter int H_VALID = VGA_H_VALID,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BACK  = VGA_V_BACK,
    parameter int V_VALID = VGA_V_VALID,
    parameter int V_FRONT = VGA_V_FRONT
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    input  logic [11:0]      pix_data,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             pix_req,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [11:0]      rgb,
    output logic             frame_start
);

    localparam int H_TOTAL = vga_total(H_SYNC, H_BACK, H_VALID, H_FRONT);
    localparam int V_TOTAL = vga_total(V_SYNC, V_BACK, V_VALID, V_FRONT);
    localparam int H_ACT   = H_SYNC + H_BACK;
    localparam int V_ACT   = V_SYNC + V_BACK;

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t     h_cnt, v_cnt;
    logic     h_wrap;
    logic     h_vis, v_vis;
    vga_ctl_t ctl_raw, ctl_d1, ctl_d2;

    assign h_wrap = (h_cnt == cnt_t'(H_TOTAL - 1));

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            if (v_cnt == cnt_t'(V_TOTAL - 1)) v_cnt <= '0;
            else                               v_cnt <= v_cnt + cnt_t'(1);
        end else begin
            h_cnt <= h_cnt + cnt_t'(1);
        end
    end

    assign h_vis   = (h_cnt >= cnt_t'(H_ACT)) && (h_cnt < cnt_t'(H_ACT + H_VALID));
    assign v_vis   = (v_cnt >= cnt_t'(V_ACT)) && (v_cnt < cnt_t'(V_ACT + V_VALID));
    assign pix_req = h_vis && v_vis;

    // Coordinates are forced to 0 outside the visible area so the generator
    // never sees an out-of-range address.
    assign pix_x = pix_req ? (h_cnt - cnt_t'(H_ACT)) : '0;
    assign pix_y = pix_req ? (v_cnt - cnt_t'(V_ACT)) : '0;

    // vsync flips only at h_cnt == 0, the same clock hs_raw goes low, so the
    // vsync edge always lands on an hsync falling edge.
    assign ctl_raw = '{hs:  (h_cnt >= cnt_t'(H_SYNC)),
                       vs:  (v_cnt >= cnt_t'(V_SYNC)),
                       req: pix_req,
                       fs:  (h_cnt == '0) && (v_cnt == '0)};

    // Two single-stage lines rather than one of depth 2: stage 1 is needed on
    // its own to gate pix_data, which arrives one clock after pix_req.
    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (1),
        .RST_VAL (CTL_IDLE)
    ) u_stage1 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .din       (ctl_raw),
        .dout      (ctl_d1)
    );

    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (1),
        .RST_VAL (CTL_IDLE)
    ) u_stage2 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .din       (ctl_d1),
        .dout      (ctl_d2)
    );

    // Known select means an X/garbage pix_data outside the visible area can
    // never reach the pins.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rgb <= RGB_BLACK;
        else            rgb <= ctl_d1.req ? pix_data : RGB_BLACK;
    end

    assign hsync       = ctl_d2.hs;
    assign vsync       = ctl_d2.vs;
    assign de          = ctl_d2.req;
    assign frame_start = ctl_d2.fs;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a default 640x480 instance checked over reset, the first
// visible lines and a mid-frame reset; a tiny-timing instance checked over
// whole frames (period, vsync width, visible-area bounds).
module tb_vga_timing_ctrl;

    logic        vga_clk = 1'b0;
    logic        sys_rst_n, s_rst_n;
    logic        xsel = 1'b0;

    logic [11:0] pix_data, rgb;
    logic [9:0]  pix_x, pix_y;
    logic        pix_req, hsync, vsync, de, frame_start;

    logic [11:0] s_pix_data, s_rgb;
    logic [9:0]  s_pix_x, s_pix_y;
    logic        s_pix_req, s_hsync, s_vsync, s_de, s_frame_start;

    int total = 0, bad = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_ctrl u_dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .hsync(hsync),
        .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start));

    // Tiny timing: H 4/3/8/2 (total 17, act 7), V 2/3/5/2 (total 12, act 5).
    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VALID(5), .V_FRONT(2)
    ) u_small (
        .vga_clk(vga_clk), .sys_rst_n(s_rst_n), .pix_data(s_pix_data),
        .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_req(s_pix_req), .hsync(s_hsync),
        .vsync(s_vsync), .de(s_de), .rgb(s_rgb), .frame_start(s_frame_start));

    // Pixel generator model: registered {row, column}; garbage (FFF or X)
    // whenever no pixel is requested.
    always_ff @(posedge vga_clk) begin
        xsel       <= ~xsel;
        pix_data   <= pix_req   ? {pix_y[3:0], pix_x[7:0]}     : (xsel ? 12'hFFF : 12'hxxx);
        s_pix_data <= s_pix_req ? {s_pix_y[3:0], s_pix_x[7:0]} : (xsel ? 12'hxxx : 12'hFFF);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor state, main instance (t = rising edges since last release).
    int t = 0, mon_en = 1;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
    int hs_fall_n = 0, hs_fall_t0 = 0, hs_fall_t1 = 0, last_hs_fall = 0;
    int hs_low_len = 0, hs_low_bad = 0, hs_per_bad = 0;
    int vs_low_len = 0, vs_low_first = 0, vs_edge_bad = 0;
    int de_rise_t = 0, de_runs = 0, de_n = 0, de_len_bad = 0, de_hs_bad = 0;
    int pix_bad = 0, leak = 0, fs_cnt = 0, fs_first = 0;
    logic [11:0] first_rgb = 12'hBAD, last_rgb0 = 12'hBAD;

    // Monitor state, small instance.
    int ts = 0;
    logic s_prev_vs = 1'b1;
    int s_vs_len = 0, s_vs_first = 0, s_fs_n = 0, s_fs_t0 = 0, s_fs_t1 = 0;
    int s_req_cnt = 0, s_req_first = 0, s_req_last = 0, s_xy_bad = 0, s_leak = 0;

    task automatic tick();
        logic [11:0] exp_px;
        @(negedge vga_clk);
        t++;
        ts++;
        if (mon_en != 0) begin
            if (prev_hs && !hsync) begin
                if (hs_fall_n == 0) hs_fall_t0 = t;
                if (hs_fall_n == 1) hs_fall_t1 = t;
                if (hs_fall_n > 0 && (t - last_hs_fall) != 800) hs_per_bad++;
                hs_fall_n++;
                last_hs_fall = t;
            end
            if (!prev_hs && hsync) begin
                if (hs_low_len != 96) hs_low_bad++;
                hs_low_len = 0;
            end
            if (!hsync) hs_low_len++;

            if (prev_vs && !vsync && !(prev_hs && !hsync)) vs_edge_bad++;
            if (!vsync) vs_low_len++;
            if (!prev_vs && vsync && vs_low_first == 0) vs_low_first = vs_low_len;

            if (!prev_de && de) begin
                if (de_runs == 0) de_rise_t = t;
                if ((t - last_hs_fall) != 144) de_hs_bad++;
                de_n = 0;
            end
            if (prev_de && !de) begin
                if (de_n != 640) de_len_bad++;
                de_runs++;
            end
            if (de) begin
                exp_px = {de_runs[3:0], de_n[7:0]};
                if (rgb !== exp_px) pix_bad++;
                if (de_runs == 0 && de_n == 0)   first_rgb = rgb;
                if (de_runs == 0 && de_n == 639) last_rgb0 = rgb;
                de_n++;
            end
            if (!de && rgb !== 12'h000) leak++;
            if (frame_start) begin
                if (fs_cnt == 0) fs_first = t;
                fs_cnt++;
            end
            prev_hs = hsync;
            prev_vs = vsync;
            prev_de = de;
        end

        if (ts <= 203 && s_pix_req) begin
            if (s_req_cnt == 0) s_req_first = ts;
            s_req_last = ts;
            s_req_cnt++;
        end
        if (!s_pix_req && (s_pix_x != 0 || s_pix_y != 0)) s_xy_bad++;
        if (s_pix_req && (s_pix_x >= 8 || s_pix_y >= 5)) s_xy_bad++;
        if (!s_vsync) s_vs_len++;
        if (!s_prev_vs && s_vsync && s_vs_first == 0) s_vs_first = s_vs_len;
        s_prev_vs = s_vsync;
        if (s_frame_start) begin
            if (s_fs_n == 0) s_fs_t0 = ts;
            if (s_fs_n == 1) s_fs_t1 = ts;
            s_fs_n++;
        end
        if (!s_de && s_rgb !== 12'h000) s_leak++;
    endtask

    initial begin
        int p2_leak;
        sys_rst_n = 1'b0;
        s_rst_n   = 1'b0;
        repeat (10) @(negedge vga_clk);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_fs", frame_start, 0);

        sys_rst_n = 1'b1;
        s_rst_n   = 1'b1;
        t  = 0;
        ts = 0;
        while (t < 30046) tick();

        chk("fs_first_t", fs_first, 2);
        chk("fs_pulses", fs_cnt, 1);
        chk("hs_fall0_t", hs_fall_t0, 2);
        chk("hs_fall1_t", hs_fall_t1, 802);
        chk("hs_low_bad", hs_low_bad, 0);
        chk("hs_period_bad", hs_per_bad, 0);
        chk("vs_low_len", vs_low_first, 1600);
        chk("vs_edge_bad", vs_edge_bad, 0);
        chk("de_rise_t", de_rise_t, 28146);
        chk("de_runs", de_runs, 2);
        chk("de_len_bad", de_len_bad, 0);
        chk("de_hs_offset_bad", de_hs_bad, 0);
        chk("first_pixel", first_rgb, 12'h000);
        chk("last_pixel_l0", last_rgb0, 12'h07F);
        chk("pixel_bad", pix_bad, 0);
        chk("rgb_leak", leak, 0);

        chk("s_fs0_t", s_fs_t0, 2);
        chk("s_frame_period", s_fs_t1 - s_fs_t0, 204);
        chk("s_vs_low_len", s_vs_first, 34);
        chk("s_req_count", s_req_cnt, 40);
        chk("s_req_first", s_req_first, 92);
        chk("s_req_last", s_req_last, 167);
        chk("s_xy_bad", s_xy_bad, 0);
        chk("s_rgb_leak", s_leak, 0);

        // Row 2, column 300 is on the pins right now.
        chk("mid_de", de, 1);
        chk("mid_rgb", rgb, 12'h22C);
        mon_en = 0;
        #1 sys_rst_n = 1'b0;
        #1;
        chk("async_de", de, 0);
        chk("async_rgb", rgb, 0);
        chk("async_hsync", hsync, 1);
        repeat (3) @(negedge vga_clk);
        chk("hold_rgb", rgb, 0);
        sys_rst_n = 1'b1;
        t = 0;
        p2_leak = 0;
        tick();
        tick();
        chk("fs_after_rst", frame_start, 1);
        while (!de && t < 30000) begin
            tick();
            if (!de && rgb !== 12'h000) p2_leak++;
        end
        chk("de_after_rst_t", t, 35 * 800 + 144 + 2);
        chk("post_rst_leak", p2_leak, 0);
        chk("post_rst_first_px", rgb, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
